// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the decode stage.
// Contents:
//   - major opcode constants
//   - ALU operation enum (4 bits, carried to EX on ex_alu_op)
//   - result-select encodings for the writeback mux
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // funct3 -> ALU op for OP / OP-IMM. alt selects SUB/SRA (instr[30]);
    // the caller decides whether alt is meaningful for funct3=000.
    function automatic alu_op_e funct3_alu_op(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I decoder: instruction word -> immediate and
// control bits for the EX stage.
// Ports:
//   instr          in  instruction word
//   imm            out sign-extended immediate for the instruction format
//   alu_op         out ALU operation
//   alu_src_a_pc   out ALU A operand is PC
//   alu_src_b_imm  out ALU B operand is immediate
//   reg_write, mem_read, mem_write, branch, jump, jalr  out control enables
//   result_src     out writeback source select
//   illegal        out opcode not recognised
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output alu_op_e     alu_op,
    output logic        alu_src_a_pc,
    output logic        alu_src_b_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        jalr,
    output logic [1:0]  result_src,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm           = '0;
        alu_op        = ALU_ADD;
        alu_src_a_pc  = 1'b0;
        alu_src_b_imm = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        jump          = 1'b0;
        jalr          = 1'b0;
        result_src    = RES_ALU;
        illegal       = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm           = imm_u;
                alu_op        = ALU_PASSB;
                alu_src_b_imm = 1'b1;
                reg_write     = 1'b1;
            end
            OPC_AUIPC: begin
                imm           = imm_u;
                alu_src_a_pc  = 1'b1;
                alu_src_b_imm = 1'b1;
                reg_write     = 1'b1;
            end
            OPC_JAL: begin
                imm           = imm_j;
                alu_src_a_pc  = 1'b1;
                alu_src_b_imm = 1'b1;
                jump          = 1'b1;
                reg_write     = 1'b1;
                result_src    = RES_PC4;
            end
            OPC_JALR: begin
                imm           = imm_i;
                alu_src_b_imm = 1'b1;
                jump          = 1'b1;
                jalr          = 1'b1;
                reg_write     = 1'b1;
                result_src    = RES_PC4;
            end
            OPC_BRANCH: begin
                imm    = imm_b;
                alu_op = ALU_SUB;
                branch = 1'b1;
            end
            OPC_LOAD: begin
                imm           = imm_i;
                alu_src_b_imm = 1'b1;
                mem_read      = 1'b1;
                reg_write     = 1'b1;
                result_src    = RES_MEM;
            end
            OPC_STORE: begin
                imm           = imm_s;
                alu_src_b_imm = 1'b1;
                mem_write     = 1'b1;
            end
            OPC_OP_IMM: begin
                imm           = imm_i;
                // No SUBI: bit 30 only distinguishes SRAI from SRLI.
                alu_op        = funct3_alu_op(funct3, (funct3 == 3'b101) && instr[30]);
                alu_src_b_imm = 1'b1;
                reg_write     = 1'b1;
            end
            OPC_OP: begin
                alu_op    = funct3_alu_op(funct3, instr[30]);
                reg_write = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Treated as NOPs: every enable stays low.
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I instruction-decode stage plus ID/EX pipeline register.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_valid/if_ready/if_instr/if_pc   handshake and payload from IF
//   flush                       kills held and incoming instruction
//   a1, a2 / rd1, rd2           register-file read addresses and data
//   wb_we, wb_rd, wb_data       writeback port, used for bypass
//   ex_valid/ex_ready           handshake toward EX
//   ex_*                        registered operands, immediate and control
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN   = 32,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    input  logic            flush,
    output logic [4:0]      a1,
    output logic [4:0]      a2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [31:0]     ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [4:0]      ex_rd,
    output logic [31:0]     ex_imm,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src_a_pc,
    output logic            ex_alu_src_b_imm,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_jalr,
    output logic [1:0]      ex_result_src,
    output logic [2:0]      ex_funct3,
    output logic            ex_illegal
);

    // Decoder outputs for the instruction currently offered by IF.
    logic [31:0] dec_imm;
    alu_op_e     dec_alu_op;
    logic        dec_src_a_pc;
    logic        dec_src_b_imm;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_branch;
    logic        dec_jump;
    logic        dec_jalr;
    logic [1:0]  dec_result_src;
    logic        dec_illegal;

    rv32i_decoder u_decoder (
        .instr         (if_instr),
        .imm           (dec_imm),
        .alu_op        (dec_alu_op),
        .alu_src_a_pc  (dec_src_a_pc),
        .alu_src_b_imm (dec_src_b_imm),
        .reg_write     (dec_reg_write),
        .mem_read      (dec_mem_read),
        .mem_write     (dec_mem_write),
        .branch        (dec_branch),
        .jump          (dec_jump),
        .jalr          (dec_jalr),
        .result_src    (dec_result_src),
        .illegal       (dec_illegal)
    );

    logic        ex_valid_reg;
    logic [31:0] pc_reg;
    logic [4:0]  rd_reg;
    logic [31:0] imm_reg;
    alu_op_e     alu_op_reg;
    logic        src_a_pc_reg;
    logic        src_b_imm_reg;
    logic        reg_write_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic        branch_reg;
    logic        jump_reg;
    logic        jalr_reg;
    logic [1:0]  result_src_reg;
    logic [2:0]  funct3_reg;
    logic        illegal_reg;

    logic accept;
    logic stall;

    assign if_ready = !ex_valid_reg || ex_ready;
    assign accept   = if_valid && if_ready && !flush;
    assign stall    = ex_valid_reg && !ex_ready;

    assign a1 = if_instr[19:15];
    assign a2 = if_instr[24:20];

    // Two identical operand channels (0 = rs1, 1 = rs2).
    logic [4:0]      rf_addr [2];
    logic [XLEN-1:0] rf_data [2];
    logic [XLEN-1:0] op_next [2];
    logic [XLEN-1:0] op_reg  [2];
    logic [4:0]      idx_reg [2];

    assign rf_addr[0] = a1;
    assign rf_addr[1] = a2;
    assign rf_data[0] = rd1;
    assign rf_data[1] = rd2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // x0 forced to zero; otherwise a same-cycle write to the
            // register being read wins over the stale register-file data.
            always_comb begin
                op_next[gi] = rf_data[gi];
                if (rf_addr[gi] == 5'd0) begin
                    op_next[gi] = '0;
                end else if (wb_we && (wb_rd == rf_addr[gi])) begin
                    op_next[gi] = wb_data;
                end
            end

            // While EX is stalled the operand keeps tracking writeback to
            // its source register, so it is never stale when EX resumes.
            always_ff @(posedge clk) begin
                if (reset) begin
                    op_reg[gi]  <= '0;
                    idx_reg[gi] <= '0;
                end else if (accept) begin
                    op_reg[gi]  <= op_next[gi];
                    idx_reg[gi] <= rf_addr[gi];
                end else if (stall && wb_we && (wb_rd == idx_reg[gi]) && (idx_reg[gi] != 5'd0)) begin
                    op_reg[gi]  <= wb_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg   <= 1'b0;
            pc_reg         <= RST_PC;
            rd_reg         <= '0;
            imm_reg        <= '0;
            alu_op_reg     <= ALU_ADD;
            src_a_pc_reg   <= 1'b0;
            src_b_imm_reg  <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            branch_reg     <= 1'b0;
            jump_reg       <= 1'b0;
            jalr_reg       <= 1'b0;
            result_src_reg <= RES_ALU;
            funct3_reg     <= '0;
            illegal_reg    <= 1'b0;
        end else begin
            if (flush) begin
                ex_valid_reg <= 1'b0;
            end else if (accept) begin
                ex_valid_reg <= 1'b1;
            end else if (ex_valid_reg && ex_ready) begin
                ex_valid_reg <= 1'b0;
            end

            // accept already excludes flush, so a flushed cycle freezes payload.
            if (accept) begin
                pc_reg         <= if_pc;
                rd_reg         <= if_instr[11:7];
                imm_reg        <= dec_imm;
                alu_op_reg     <= dec_alu_op;
                src_a_pc_reg   <= dec_src_a_pc;
                src_b_imm_reg  <= dec_src_b_imm;
                reg_write_reg  <= dec_reg_write;
                mem_read_reg   <= dec_mem_read;
                mem_write_reg  <= dec_mem_write;
                branch_reg     <= dec_branch;
                jump_reg       <= dec_jump;
                jalr_reg       <= dec_jalr;
                result_src_reg <= dec_result_src;
                funct3_reg     <= if_instr[14:12];
                illegal_reg    <= dec_illegal;
            end
        end
    end

    assign ex_valid         = ex_valid_reg;
    assign ex_pc            = pc_reg;
    assign ex_rs1_val       = op_reg[0];
    assign ex_rs2_val       = op_reg[1];
    assign ex_rd            = rd_reg;
    assign ex_imm           = imm_reg;
    assign ex_alu_op        = alu_op_reg;
    assign ex_alu_src_a_pc  = src_a_pc_reg;
    assign ex_alu_src_b_imm = src_b_imm_reg;
    assign ex_reg_write     = reg_write_reg;
    assign ex_mem_read      = mem_read_reg;
    assign ex_mem_write     = mem_write_reg;
    assign ex_branch        = branch_reg;
    assign ex_jump          = jump_reg;
    assign ex_jalr          = jalr_reg;
    assign ex_result_src    = result_src_reg;
    assign ex_funct3        = funct3_reg;
    assign ex_illegal       = illegal_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point after each edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src_a_pc;
    logic        ex_alu_src_b_imm;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_jalr;
    logic [1:0]  ex_result_src;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk              (clk),
        .reset            (reset),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .flush            (flush),
        .a1               (a1),
        .a2               (a2),
        .rd1              (rd1),
        .rd2              (rd2),
        .wb_we            (wb_we),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_pc            (ex_pc),
        .ex_rs1_val       (ex_rs1_val),
        .ex_rs2_val       (ex_rs2_val),
        .ex_rd            (ex_rd),
        .ex_imm           (ex_imm),
        .ex_alu_op        (ex_alu_op),
        .ex_alu_src_a_pc  (ex_alu_src_a_pc),
        .ex_alu_src_b_imm (ex_alu_src_b_imm),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_branch        (ex_branch),
        .ex_jump          (ex_jump),
        .ex_jalr          (ex_jalr),
        .ex_result_src    (ex_result_src),
        .ex_funct3        (ex_funct3),
        .ex_illegal       (ex_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for exactly one cycle with EX ready.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        rd1      = r1;
        rd2      = r2;
        ex_ready = 1'b1;
        tick();
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_imm !== 32'h0 || ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b pc=%h imm=%h wr=%b, want 0/0/0/0", ex_valid, ex_pc, ex_imm, ex_reg_write);
        end
        reset = 1'b0;
        $display("reset: valid=%b pc=%h", ex_valid, ex_pc);
    endtask

    task automatic test_addi();
        if_instr = 32'hFFD08293;
        #1;
        checks++;
        if (a1 !== 5'd1 || a2 !== 5'd29) begin
            errors++;
            $display("FAIL addr: a1=%0d a2=%0d, want 1/29", a1, a2);
        end
        issue(32'hFFD08293, 32'h0000_0010, 32'd10, 32'd0);
        checks++;
        if (ex_valid !== 1'b1 || ex_rs1_val !== 32'd10 || ex_imm !== 32'hFFFFFFFD ||
            ex_alu_op !== 4'd0 || ex_reg_write !== 1'b1 || ex_rd !== 5'd5 ||
            ex_alu_src_b_imm !== 1'b1 || ex_pc !== 32'h10) begin
            errors++;
            $display("FAIL addi: v=%b rs1=%h imm=%h op=%0d wr=%b rd=%0d bimm=%b pc=%h, want 1/a/fffffffd/0/1/5/1/10",
                     ex_valid, ex_rs1_val, ex_imm, ex_alu_op, ex_reg_write, ex_rd, ex_alu_src_b_imm, ex_pc);
        end
        $display("addi: rs1=%h imm=%h rd=%0d", ex_rs1_val, ex_imm, ex_rd);
        // No new offer with EX ready: valid must drop, payload stays.
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h10) begin
            errors++;
            $display("FAIL drain: valid=%b pc=%h, want 0/10", ex_valid, ex_pc);
        end
    endtask

    task automatic test_x0();
        issue(32'h002001B3, 32'h20, 32'h0000DEAD, 32'h5);
        checks++;
        if (ex_rs1_val !== 32'h0 || ex_rs2_val !== 32'h5 || ex_alu_op !== 4'd0 || ex_rd !== 5'd3) begin
            errors++;
            $display("FAIL x0: rs1=%h rs2=%h op=%0d rd=%0d, want 0/5/0/3", ex_rs1_val, ex_rs2_val, ex_alu_op, ex_rd);
        end
        $display("x0: rs1=%h", ex_rs1_val);
    endtask

    task automatic test_bypass();
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        issue(32'h002081B3, 32'h24, 32'h11, 32'h22);
        wb_we = 1'b0;
        checks++;
        if (ex_rs1_val !== 32'h55 || ex_rs2_val !== 32'h22) begin
            errors++;
            $display("FAIL bypass: rs1=%h rs2=%h, want 55/22", ex_rs1_val, ex_rs2_val);
        end
        $display("bypass: rs1=%h rs2=%h", ex_rs1_val, ex_rs2_val);
    endtask

    task automatic test_stall_hold();
        issue(32'h007081B3, 32'h40, 32'h11, 32'h22);   // ADD x3,x1,x7
        // EX stalls; IF keeps offering a different instruction.
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instr = 32'hFFD08293; if_pc = 32'h44; rd1 = 32'hAA; rd2 = 32'hBB;
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h77;   // unrelated register
        #1;
        checks++;
        if (if_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready0: if_ready=%b, want 0", if_ready);
        end
        tick();
        checks++;
        if (ex_rs2_val !== 32'h22 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_c1: rs2=%h if_ready=%b, want 22/0", ex_rs2_val, if_ready);
        end
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h99;
        tick();
        wb_we = 1'b0;
        checks++;
        if (ex_rs2_val !== 32'h99 || ex_rs1_val !== 32'h11 || ex_pc !== 32'h40 || ex_rd !== 5'd3 ||
            ex_imm !== 32'h0 || ex_valid !== 1'b1 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_c2: rs2=%h rs1=%h pc=%h rd=%0d imm=%h v=%b rdy=%b, want 99/11/40/3/0/1/0",
                     ex_rs2_val, ex_rs1_val, ex_pc, ex_rd, ex_imm, ex_valid, if_ready);
        end
        tick();
        checks++;
        if (ex_rs2_val !== 32'h99 || ex_pc !== 32'h40 || if_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_c3: rs2=%h pc=%h rdy=%b, want 99/40/0", ex_rs2_val, ex_pc, if_ready);
        end
        $display("stall: rs1=%h rs2=%h pc=%h", ex_rs1_val, ex_rs2_val, ex_pc);
    endtask

    task automatic test_flush();
        // Stage still holds the stalled payload with ex_valid=1.
        flush = 1'b1; if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h80;
        tick();
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h40) begin
            errors++;
            $display("FAIL flush: valid=%b pc=%h, want 0/40", ex_valid, ex_pc);
        end
        $display("flush: valid=%b pc=%h", ex_valid, ex_pc);
    endtask

    task automatic test_branch_illegal();
        issue(32'hFE000CE3, 32'h100, 32'h1, 32'h1);
        checks++;
        if (ex_imm !== 32'hFFFFFFF8 || ex_branch !== 1'b1 || ex_reg_write !== 1'b0 ||
            ex_alu_op !== 4'd1 || ex_funct3 !== 3'b000 || ex_pc !== 32'h100) begin
            errors++;
            $display("FAIL beq: imm=%h br=%b wr=%b op=%0d f3=%0d pc=%h, want fffffff8/1/0/1/0/100",
                     ex_imm, ex_branch, ex_reg_write, ex_alu_op, ex_funct3, ex_pc);
        end
        $display("beq: imm=%h br=%b", ex_imm, ex_branch);
        issue(32'h0000007F, 32'h104, 32'h0, 32'h0);
        checks++;
        if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 || ex_reg_write !== 1'b0 || ex_branch !== 1'b0 ||
            ex_jump !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0 || ex_alu_src_b_imm !== 1'b0) begin
            errors++;
            $display("FAIL illegal: ill=%b v=%b wr=%b br=%b j=%b mr=%b mw=%b bimm=%b, want 1/1/0/0/0/0/0/0",
                     ex_illegal, ex_valid, ex_reg_write, ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_alu_src_b_imm);
        end
        $display("illegal: ill=%b", ex_illegal);
    endtask

    task automatic test_back_to_back();
        // LUI, JAL, SRAI offered on consecutive cycles.
        issue(32'h123450B7, 32'h200, 32'h0, 32'h0);
        checks++;
        if (ex_imm !== 32'h12345000 || ex_alu_op !== 4'd10 || ex_alu_src_b_imm !== 1'b1 ||
            ex_reg_write !== 1'b1 || ex_illegal !== 1'b0) begin
            errors++;
            $display("FAIL lui: imm=%h op=%0d bimm=%b wr=%b ill=%b, want 12345000/10/1/1/0",
                     ex_imm, ex_alu_op, ex_alu_src_b_imm, ex_reg_write, ex_illegal);
        end
        issue(32'h000000EF, 32'h204, 32'h0, 32'h0);
        checks++;
        if (ex_jump !== 1'b1 || ex_jalr !== 1'b0 || ex_alu_src_a_pc !== 1'b1 || ex_result_src !== 2'b10 ||
            ex_rd !== 5'd1 || ex_pc !== 32'h204 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL jal: j=%b jalr=%b apc=%b res=%0d rd=%0d pc=%h v=%b, want 1/0/1/2/1/204/1",
                     ex_jump, ex_jalr, ex_alu_src_a_pc, ex_result_src, ex_rd, ex_pc, ex_valid);
        end
        issue(32'h4010D093, 32'h208, 32'h80000000, 32'h0);
        checks++;
        if (ex_alu_op !== 4'd7 || ex_rs1_val !== 32'h80000000 || ex_funct3 !== 3'b101 || ex_alu_src_b_imm !== 1'b1) begin
            errors++;
            $display("FAIL srai: op=%0d rs1=%h f3=%0d bimm=%b, want 7/80000000/5/1",
                     ex_alu_op, ex_rs1_val, ex_funct3, ex_alu_src_b_imm);
        end
        $display("back_to_back: op=%0d pc=%h", ex_alu_op, ex_pc);
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; flush = 1'b0;
        rd1 = 32'h0; rd2 = 32'h0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; ex_ready = 1'b1;
        test_reset();
        test_addi();
        test_x0();
        test_bypass();
        test_stall_hold();
        test_flush();
        test_branch_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
